cam_capture_ctrl: RTL
=====================

CAM_CAPTURE_CTRL -- requirements
Module: cam_capture_ctrl

Interface
REQ-001 Parameter H_PIXELS, default 160, pixels per line.
REQ-002 Parameter V_LINES, default 120, lines per frame.
REQ-003 Parameter ADDR_W, default 15, frame-buffer address width; H_PIXELS*V_LINES SHALL be at most 2^ADDR_W.
REQ-004 clk  input  1  system clock, rising edge; reset reset, synchronous, active-high; clock clk.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 start  input  1  one-cycle request to capture the next full frame.
REQ-007 abort  input  1  one-cycle request to cancel a capture in progress.
REQ-008 cam_pclk  input  1  camera pixel clock, asynchronous to clk.
REQ-009 cam_vsync  input  1  camera frame sync, asynchronous; high between frames.
REQ-010 cam_href  input  1  camera line-valid, asynchronous.
REQ-011 cam_data  input  8  camera byte bus, RGB565, high byte first.
REQ-012 buf_we  output  1  frame-buffer write strobe, one cycle per pixel.
REQ-013 buf_addr  output  ADDR_W  frame-buffer write address.
REQ-014 buf_wdata  output  8  RGB332 pixel.
REQ-015 busy  output  1  high in any state except IDLE.
REQ-016 done  output  1  sticky; frame completed.
REQ-017 err_line  output  1  sticky; a line length differed from H_PIXELS.
REQ-018 err_ovf  output  1  sticky; pixels or lines exceeded the frame size.
REQ-019 pix_count  output  ADDR_W+1  pixels written in the current or last frame.

Function
REQ-020 cam_pclk, cam_vsync, cam_href and cam_data SHALL each pass through a 2-flop synchronizer in clk; clk SHALL be at least 4x pclk.
REQ-021 A pclk rise SHALL be detected as synchronized pclk 1 now and 0 the previous cycle; cam_href and cam_data SHALL be sampled on that cycle.
REQ-022 FSM states SHALL be IDLE, WAIT_VS, WAIT_START, CAPTURE and FINISH.
REQ-023 IDLE: on start, go to WAIT_VS; clear done, err_line, err_ovf and pix_count; clear the address and line counters.
REQ-024 WAIT_VS: wait for synchronized vsync high (inter-frame gap), then go to WAIT_START.
REQ-025 WAIT_START: on a synchronized vsync falling edge, go to CAPTURE; this guarantees a complete frame.
REQ-026 CAPTURE: on a pclk rise with href high, a phase bit SHALL toggle.
  - Phase 0: latch the byte as hi.
  - Phase 1: form pixel {hi[7:5], hi[2:0], byte[4:3]} and present it on buf_wdata.
REQ-027 On each phase-1 byte, buf_we SHALL pulse for exactly one clk cycle with buf_addr equal to the current address; the address and pix_count SHALL then increment by 1.
REQ-028 A per-line column counter SHALL count pixels while href is high.
REQ-029 On a synchronized href falling edge:
  - the phase SHALL reset to 0;
  - if column != H_PIXELS, err_line SHALL set;
  - the column SHALL clear and the line counter SHALL increment.
REQ-030 A write with address >= H_PIXELS*V_LINES, or a line beyond V_LINES, SHALL be suppressed (no buf_we) and SHALL set err_ovf; the address SHALL NOT wrap.
REQ-031 A trailing odd byte at an href fall SHALL be discarded.
REQ-032 CAPTURE: on a synchronized vsync rising edge, go to FINISH.
REQ-033 FINISH SHALL last one cycle: set done, then go to IDLE.
REQ-034 abort in any non-IDLE state SHALL return to IDLE within one cycle.
  - No further buf_we.
  - done SHALL stay 0.
  - Error flags and pix_count SHALL retain their values.
REQ-035 start while busy SHALL be ignored; start and abort in the same IDLE cycle SHALL start the capture, since abort has no effect in IDLE.
REQ-036 If a vsync rise and a pixel write occur on the same cycle, the pixel SHALL be written before the transition.
REQ-037 Latency: buf_we SHALL assert no more than 4 clk cycles after the raw pclk rise carrying the low byte.

Reset
REQ-038 During reset:
  - the FSM SHALL go to IDLE;
  - busy, done, err_line, err_ovf and buf_we SHALL be 0;
  - buf_addr, buf_wdata and pix_count SHALL be 0;
  - synchronizer flops and the phase SHALL clear.
REQ-039 Reset asserted mid-capture SHALL take effect on the next clk edge, with no further writes.

Verification
REQ-040 Nominal frame, H_PIXELS=4, V_LINES=2, clk=4x pclk, start, then vsync 1->0 and 2 lines of 8 bytes (hi=0xE7, lo=0x18), then vsync rise -> 8 buf_we pulses, addr 0..7, wdata 0xFF, done=1, pix_count=8, no errors.
REQ-041 Start while vsync is already low mid-frame -> no writes until the next vsync high->low; the first write is at addr 0.
REQ-042 Short line of 3 pixels -> err_line=1; the remaining pixels are still written; done=1.
REQ-043 Third line in a V_LINES=2 frame -> no buf_we for line 3; err_ovf=1; buf_addr stops at 7.
REQ-044 abort after 3 pixels -> busy=0 next cycle, no further buf_we, done=0, pix_count=3.
REQ-045 Reset asserted during CAPTURE, then start pulsed while busy -> outputs are all 0; the start during busy is ignored; the next start in IDLE captures normally.

Source files
------------

// File: rtl/cam_capture_ctrl.sv
// Camera capture controller: takes an 8-bit RGB565 camera stream on an
// unrelated pixel clock, resynchronises it into clk, waits for a clean frame
// boundary and writes one RGB332 byte per pixel into a frame buffer.
// Reports completion, line-length and overflow errors as sticky flags.
module cam_capture_ctrl #(
  parameter int H_PIXELS = 160,
  parameter int V_LINES  = 120,
  parameter int ADDR_W   = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              cam_pclk_i,
  input  logic              cam_vsync_i,
  input  logic              cam_href_i,
  input  logic [7:0]        cam_data_i,
  output logic              buf_we_o,
  output logic [ADDR_W-1:0] buf_addr_o,
  output logic [7:0]        buf_wdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_line_o,
  output logic              err_ovf_o,
  output logic [ADDR_W:0]   pix_count_o
);

  // Counters are one step wider than their limit so an over-long line or an
  // extra line can be recognised without wrapping back into the valid range.
  localparam int COL_W  = $clog2(H_PIXELS + 2);
  localparam int LINE_W = $clog2(V_LINES + 1);

  localparam logic [ADDR_W:0]   FRAME_PIX = (ADDR_W+1)'(H_PIXELS * V_LINES);
  localparam logic [COL_W-1:0]  COL_MAX   = COL_W'(H_PIXELS);
  localparam logic [LINE_W-1:0] LINE_MAX  = LINE_W'(V_LINES);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_VS,
    WAIT_START,
    CAPTURE,
    FINISH
  } state_t;

  state_t state_q, state_d;

  logic       pclk_meta_q, pclk_sync_q, pclk_prev_q;
  logic       vsync_meta_q, vsync_sync_q, vsync_prev_q;
  logic       href_meta_q, href_sync_q, href_prev_q;
  logic [7:0] data_meta_q, data_sync_q;

  logic              phase_q, phase_d;
  logic [7:0]        hi_q, hi_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [ADDR_W:0]   addr_q, addr_d;
  logic              buf_we_q, buf_we_d;
  logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
  logic [7:0]        buf_wdata_q, buf_wdata_d;
  logic              done_q, done_d;
  logic              err_line_q, err_line_d;
  logic              err_ovf_q, err_ovf_d;

  logic pclk_rise, vsync_rise, vsync_fall, href_fall;

  // Two-flop synchronisers for every camera input plus one history flop for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      pclk_meta_q  <= 1'b0;
      pclk_sync_q  <= 1'b0;
      pclk_prev_q  <= 1'b0;
      vsync_meta_q <= 1'b0;
      vsync_sync_q <= 1'b0;
      vsync_prev_q <= 1'b0;
      href_meta_q  <= 1'b0;
      href_sync_q  <= 1'b0;
      href_prev_q  <= 1'b0;
      data_meta_q  <= 8'h00;
      data_sync_q  <= 8'h00;
    end else begin
      pclk_meta_q  <= cam_pclk_i;
      pclk_sync_q  <= pclk_meta_q;
      pclk_prev_q  <= pclk_sync_q;
      vsync_meta_q <= cam_vsync_i;
      vsync_sync_q <= vsync_meta_q;
      vsync_prev_q <= vsync_sync_q;
      href_meta_q  <= cam_href_i;
      href_sync_q  <= href_meta_q;
      href_prev_q  <= href_sync_q;
      data_meta_q  <= cam_data_i;
      data_sync_q  <= data_meta_q;
    end
  end

  assign pclk_rise  = pclk_sync_q & ~pclk_prev_q;
  assign vsync_rise = vsync_sync_q & ~vsync_prev_q;
  assign vsync_fall = ~vsync_sync_q & vsync_prev_q;
  assign href_fall  = ~href_sync_q & href_prev_q;

  // State and datapath registers; everything clears on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      phase_q     <= 1'b0;
      hi_q        <= 8'h00;
      col_q       <= '0;
      line_q      <= '0;
      addr_q      <= '0;
      buf_we_q    <= 1'b0;
      buf_addr_q  <= '0;
      buf_wdata_q <= 8'h00;
      done_q      <= 1'b0;
      err_line_q  <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      hi_q        <= hi_d;
      col_q       <= col_d;
      line_q      <= line_d;
      addr_q      <= addr_d;
      buf_we_q    <= buf_we_d;
      buf_addr_q  <= buf_addr_d;
      buf_wdata_q <= buf_wdata_d;
      done_q      <= done_d;
      err_line_q  <= err_line_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

  // Next-state logic: frame sequencing, byte pairing, bounds checks and abort handling.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    hi_d        = hi_q;
    col_d       = col_q;
    line_d      = line_q;
    addr_d      = addr_q;
    buf_we_d    = 1'b0;
    buf_addr_d  = buf_addr_q;
    buf_wdata_d = buf_wdata_q;
    done_d      = done_q;
    err_line_d  = err_line_q;
    err_ovf_d   = err_ovf_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d    = WAIT_VS;
          done_d     = 1'b0;
          err_line_d = 1'b0;
          err_ovf_d  = 1'b0;
          addr_d     = '0;
          col_d      = '0;
          line_d     = '0;
          phase_d    = 1'b0;
        end
      end
      WAIT_VS: begin
        if (vsync_sync_q) state_d = WAIT_START;
      end
      WAIT_START: begin
        if (vsync_fall) state_d = CAPTURE;
      end
      CAPTURE: begin
        if (pclk_rise && href_sync_q) begin
          phase_d = ~phase_q;
          if (!phase_q) begin
            hi_d = data_sync_q;
          end else begin
            if (col_q <= COL_MAX) col_d = col_q + COL_W'(1);
            if ((addr_q >= FRAME_PIX) || (line_q >= LINE_MAX)) begin
              err_ovf_d = 1'b1;
            end else begin
              buf_we_d    = 1'b1;
              buf_addr_d  = addr_q[ADDR_W-1:0];
              buf_wdata_d = {hi_q[7:5], hi_q[2:0], data_sync_q[4:3]};
              addr_d      = addr_q + (ADDR_W+1)'(1);
            end
          end
        end
        if (href_fall) begin
          phase_d = 1'b0;
          if (col_q != COL_MAX) err_line_d = 1'b1;
          col_d = '0;
          if (line_q < LINE_MAX) line_d = line_q + LINE_W'(1);
        end
        if (vsync_rise) state_d = FINISH;
      end
      FINISH: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if ((state_q != IDLE) && abort_i) begin
      state_d     = IDLE;
      buf_we_d    = 1'b0;
      buf_addr_d  = buf_addr_q;
      buf_wdata_d = buf_wdata_q;
      addr_d      = addr_q;
      done_d      = done_q;
      err_line_d  = err_line_q;
      err_ovf_d   = err_ovf_q;
    end
  end

  assign buf_we_o    = buf_we_q;
  assign buf_addr_o  = buf_addr_q;
  assign buf_wdata_o = buf_wdata_q;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign err_line_o  = err_line_q;
  assign err_ovf_o   = err_ovf_q;
  assign pix_count_o = addr_q;

endmodule
